mac_array_ctrl: RTL and testbench
=================================

// Module: mac_array_ctrl
// PURPOSE
//  Sequencer for mac_array_nn: runs one NxN matrix-vector product y = W*x.
//  Splits the product into N/4 row-tile passes. Each pass does four things:
//  clears the accumulators, streams x[0..N-1] with matching weight columns,
//  waits for the MAC pipeline to drain, then flags the 4 results for capture.
//  Sits between the layer-level controller (start/done) and the
//  activation buffer, weight_mem_if and mac_array_nn.
// PARAMETERS
//  N         8   vector length; must be a multiple of 4, N/4 <= NUM_ACC (elaboration error otherwise)
//  NUM_ACC   8   accumulator cells per MAC; acc_sel range
//  N_MACS    4   physical MACs (fixed 4)
//  DRAIN_CYC 2   cycles waited after last issue before results are read
// PORTS
//  clk             in   1                clock
//  rst             in   1                synchronous active-high reset
//  start           in   1                pulse: begin product (accepted only in IDLE)
//  abort           in   1                cancel current product
//  busy            out  1                high from accepted start until done/abort
//  done            out  1                1-cycle pulse, product complete
//  act_re          out  1                activation buffer read enable (1-cycle read latency)
//  act_addr        out  $clog2(N)        activation index (column)
//  w_re            out  1                weight_mem_if fetch enable (1-cycle latency)
//  w_col           out  $clog2(N)        weight column
//  w_row_tile      out  $clog2(N/4)+1    row-tile (pass) index
//  w_ready         in   1                weight_mem_if can accept a fetch; low = stall
//  valid_ctrl      out  3*N_MACS         per-MAC mode, to mac_array_nn
//  clear           out  N_MACS           per-MAC accumulator clear
//  valid_weight_in out  N_MACS           per-MAC weight-valid strobe
//  acc_sel_tile    out  3                accumulator cell select = pass index
//  res_valid       out  1                1-cycle pulse: acc_out_0..3 hold y[res_row_base+0..3]
//  res_row_base    out  $clog2(N)+1      pass*4, held stable while res_valid is high
// BEHAVIOUR
//  - Reset: FSM=IDLE. Counters, busy, done, act_re, w_re, clear, valid_ctrl,
//    valid_weight_in, acc_sel_tile, res_valid and res_row_base are all 0.
//  - FSM: IDLE -> CLEAR -> ISSUE -> DRAIN -> RESULT -> (CLEAR of next pass | DONE) -> IDLE.
//  - IDLE: start=1 -> CLEAR with pass=0. A start seen in any other state is ignored.
//  - CLEAR (1 cycle): clear=4'b1111. acc_sel_tile=pass, held constant for the whole pass.
//  - ISSUE: one issue per cycle while w_ready=1.
//    - Each issue drives act_re=w_re=1, act_addr=w_col=col, w_row_tile=pass.
//    - w_ready=0: no issue that cycle, col holds.
//    - Leave ISSUE after the issue with col=N-1.
//  - Strobes are registered 1 cycle after each issue, aligned with the returned data:
//    valid_weight_in=4'b1111, valid_ctrl={4{3'b001}} (a_in_0 compute path).
//    At all other times both are 0.
//  - DRAIN: DRAIN_CYC cycles, covering the last strobe and the array's acc_sel register.
//  - RESULT (1 cycle): res_valid=1, res_row_base=pass*4.
//    - pass<N/4-1: pass++, go to CLEAR.
//    - else: go to DONE.
//  - DONE (1 cycle): done=1, busy drops the same cycle. Then IDLE.
//  - Cycle count, no stalls: start accepted at cycle 0 -> done at cycle (N/4)*(N+DRAIN_CYC+2)+1.
//  - abort, any non-IDLE state: IDLE next cycle.
//    - In that same next cycle all strobes, clear and res_valid are 0.
//    - done is not pulsed; a strobe already pending from an issue is dropped.
//    - abort has priority over start and over w_ready.
//  - rst mid-operation: identical to the reset state next cycle.
//  - Counters use exact widths; col wraps to 0 only on entry to CLEAR.
// TESTING
//  - N=8, w_ready=1, start@0: clear=4'hF at cycles 1 and 13.
//    8 strobes each with acc_sel_tile 0 then 1; res_valid at 12 (base 0) and 24 (base 4); done at 25.
//  - Stall: w_ready=0 for 3 cycles mid-pass 0 -> exactly 8 issues, col never skipped or repeated, done at 28.
//  - abort in ISSUE at col=3 -> next cycle IDLE, busy=0, no done.
//    A new start then runs cleanly from pass 0, col 0.
//  - start pulses while busy -> ignored; exactly one done, N/4 res_valid pulses.
//  - rst asserted in DRAIN -> all outputs 0 the next cycle; FSM in IDLE.
//  - N=16: 4 passes, res_row_base 0,4,8,12, acc_sel_tile 0..3, done at cycle 4*20+1=81.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// -----------------------------------------------------------------------------
// mac_array_ctrl
//   Sequencer for mac_array_nn. Runs one NxN matrix-vector product y = W*x as
//   N/4 row-tile passes. Each pass clears the accumulators, streams x[0..N-1]
//   together with the matching weight columns, waits for the MAC pipeline to
//   drain, then flags the four accumulator results for capture.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   start           pulse, begins a product (only honoured in IDLE)
//   abort           cancels the current product, back to IDLE next cycle
//   busy            high from accepted start until done/abort
//   done            1-cycle pulse when the product is complete
//   act_re/act_addr activation buffer read (1-cycle read latency)
//   w_re/w_col      weight fetch request and column
//   w_row_tile      row-tile (pass) index of the fetch
//   w_ready         weight fetch can be accepted; low stalls issuing
//   valid_ctrl      per-MAC mode, 3 bits each
//   clear           per-MAC accumulator clear
//   valid_weight_in per-MAC weight-valid strobe, aligned with returned data
//   acc_sel_tile    accumulator cell select, equal to the pass index
//   res_valid       1-cycle pulse: MAC outputs hold y[res_row_base+0..3]
//   res_row_base    pass*4 while res_valid is high
// -----------------------------------------------------------------------------
module mac_array_ctrl #(
  parameter int N         = 8,
  parameter int NUM_ACC   = 8,
  parameter int N_MACS    = 4,
  parameter int DRAIN_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic                     act_re,
  output logic [$clog2(N)-1:0]     act_addr,
  output logic                     w_re,
  output logic [$clog2(N)-1:0]     w_col,
  output logic [$clog2(N/4):0]     w_row_tile,
  input  logic                     w_ready,
  output logic [3*N_MACS-1:0]      valid_ctrl,
  output logic [N_MACS-1:0]        clear,
  output logic [N_MACS-1:0]        valid_weight_in,
  output logic [2:0]               acc_sel_tile,
  output logic                     res_valid,
  output logic [$clog2(N):0]       res_row_base
);

  localparam int CW    = $clog2(N);
  localparam int PW    = $clog2(N/4) + 1;
  localparam int RBW   = $clog2(N) + 1;
  localparam int NPASS = N / 4;
  localparam int DW    = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  if ((N % 4) != 0 || (N / 4) > NUM_ACC || N_MACS != 4 || DRAIN_CYC < 1) begin : g_bad_cfg
    $error("mac_array_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_RESULT, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_col;
  logic [PW-1:0]   r_pass;
  logic [DW-1:0]   r_drain;
  logic            r_strobe;   // an issue happened last cycle; data arrives now

  logic w_abort;
  logic w_issue;
  logic w_last_col;
  logic w_last_pass;
  logic w_drain_done;

  assign w_abort      = abort && (r_state != S_IDLE);
  // abort outranks w_ready: no issue in the cycle the product is cancelled
  assign w_issue      = (r_state == S_ISSUE) && w_ready && !abort;
  assign w_last_col   = (r_col == CW'(N - 1));
  assign w_last_pass  = (r_pass == PW'(NPASS - 1));
  assign w_drain_done = (r_drain == DW'(DRAIN_CYC - 1));

  // State register
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // w_next unassigned and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_CLEAR;
      S_CLEAR:  w_next = S_ISSUE;
      S_ISSUE:  if (w_issue && w_last_col) w_next = S_DRAIN;
      S_DRAIN:  if (w_drain_done) w_next = S_RESULT;
      S_RESULT: w_next = w_last_pass ? S_DONE : S_CLEAR;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // Counters and the delayed strobe. Column only returns to 0 when a pass is
  // (re)entered, so after the last issue it rests at N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_col    <= '0;
      r_pass   <= '0;
      r_drain  <= '0;
      r_strobe <= 1'b0;
    end else begin
      // w_issue is already false under abort, so a pending strobe is dropped
      r_strobe <= w_issue;
      if (!w_abort) begin
        unique case (r_state)
          S_IDLE: if (start) begin
            r_col  <= '0;
            r_pass <= '0;
          end
          S_CLEAR:  r_drain <= '0;
          S_ISSUE:  if (w_issue && !w_last_col) r_col <= r_col + 1'b1;
          S_DRAIN:  r_drain <= r_drain + 1'b1;
          S_RESULT: if (!w_last_pass) begin
            r_pass <= r_pass + 1'b1;
            r_col  <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    busy            = (r_state != S_IDLE) && (r_state != S_DONE);
    done            = (r_state == S_DONE);
    act_re          = w_issue;
    w_re            = w_issue;
    act_addr        = r_col;
    w_col           = r_col;
    w_row_tile      = r_pass;
    acc_sel_tile    = busy ? 3'(r_pass) : 3'd0;
    clear           = (r_state == S_CLEAR) ? {N_MACS{1'b1}} : '0;
    valid_weight_in = r_strobe ? {N_MACS{1'b1}} : '0;
    valid_ctrl      = r_strobe ? {N_MACS{3'b001}} : '0;
    res_valid       = (r_state == S_RESULT);
    res_row_base    = res_valid ? RBW'({r_pass, 2'b00}) : '0;
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
module tb_mac_array_ctrl;

  localparam int N    = 8;
  localparam int P    = N / 4;
  localparam int D    = 2;
  localparam int MAXC = 160;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        rst, start, abort, w_ready;
  logic        busy, done, act_re, w_re, res_valid;
  logic [2:0]  act_addr, w_col, acc_sel_tile;
  logic [1:0]  w_row_tile;
  logic [11:0] valid_ctrl;
  logic [3:0]  clear, valid_weight_in, res_row_base;

  mac_array_ctrl #(.N(8), .NUM_ACC(8), .N_MACS(4), .DRAIN_CYC(2)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .act_re(act_re), .act_addr(act_addr), .w_re(w_re), .w_col(w_col),
    .w_row_tile(w_row_tile), .w_ready(w_ready), .valid_ctrl(valid_ctrl),
    .clear(clear), .valid_weight_in(valid_weight_in), .acc_sel_tile(acc_sel_tile),
    .res_valid(res_valid), .res_row_base(res_row_base)
  );

  // N=16 instance
  logic        start16, abort16, w_ready16;
  logic        busy16, done16, act_re16, w_re16, res_valid16;
  logic [3:0]  act_addr16, w_col16, clear16, valid_weight_in16;
  logic [2:0]  w_row_tile16, acc_sel_tile16;
  logic [11:0] valid_ctrl16;
  logic [4:0]  res_row_base16;

  mac_array_ctrl #(.N(16), .NUM_ACC(8), .N_MACS(4), .DRAIN_CYC(2)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .abort(abort16), .busy(busy16), .done(done16),
    .act_re(act_re16), .act_addr(act_addr16), .w_re(w_re16), .w_col(w_col16),
    .w_row_tile(w_row_tile16), .w_ready(w_ready16), .valid_ctrl(valid_ctrl16),
    .clear(clear16), .valid_weight_in(valid_weight_in16), .acc_sel_tile(acc_sel_tile16),
    .res_valid(res_valid16), .res_row_base(res_row_base16)
  );

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        act_re;
    logic [2:0]  act_addr;
    logic        w_re;
    logic [2:0]  w_col;
    logic [1:0]  w_row_tile;
    logic [11:0] valid_ctrl;
    logic [3:0]  clear;
    logic [3:0]  vwi;
    logic [2:0]  acc_sel;
    logic        res_valid;
    logic [3:0]  base;
  } obs_t;

  typedef struct packed {
    logic start;
    logic w_ready;
    obs_t exp;
  } vec_t;

  int n_checks = 0;
  int n_err    = 0;

  logic st     [MAXC];
  logic wr     [MAXC];
  obs_t exp_tr [MAXC];
  vec_t vec    [27];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.busy = busy; o.done = done; o.act_re = act_re; o.act_addr = act_addr;
    o.w_re = w_re; o.w_col = w_col; o.w_row_tile = w_row_tile;
    o.valid_ctrl = valid_ctrl; o.clear = clear; o.vwi = valid_weight_in;
    o.acc_sel = acc_sel_tile; o.res_valid = res_valid; o.base = res_row_base;
    return o;
  endfunction

  // Fields only defined while they are qualified are ignored otherwise.
  function automatic obs_t mask(input obs_t o, input obs_t e);
    obs_t r;
    r = o;
    if (!e.act_re) begin r.act_addr = '0; r.w_col = '0; r.w_row_tile = '0; end
    if (!e.res_valid) r.base = '0;
    if (!e.busy) r.acc_sel = '0;
    return r;
  endfunction

  task automatic mark_busy(input int t, input int p);
    if (t < MAXC) begin exp_tr[t].busy = 1'b1; exp_tr[t].acc_sel = 3'(p); end
  endtask

  // Reference model: walks the product as passes of issues, using the
  // pre-generated w_ready sequence, and records what each cycle must show.
  task automatic build_model();
    int c, t, k;
    for (int i = 0; i < MAXC; i++) exp_tr[i] = '0;
    c = 0;
    while (c < MAXC) begin
      if (!st[c]) begin c++; continue; end
      t = c + 1;
      for (int p = 0; p < P; p++) begin
        mark_busy(t, p);
        if (t < MAXC) exp_tr[t].clear = 4'hF;
        t++;
        k = 0;
        while (k < N && t < MAXC) begin
          mark_busy(t, p);
          if (wr[t]) begin
            exp_tr[t].act_re = 1'b1; exp_tr[t].w_re = 1'b1;
            exp_tr[t].act_addr = 3'(k); exp_tr[t].w_col = 3'(k);
            exp_tr[t].w_row_tile = 2'(p);
            if (t + 1 < MAXC) begin
              exp_tr[t+1].vwi = 4'hF; exp_tr[t+1].valid_ctrl = 12'h249;
            end
            k++;
          end
          t++;
        end
        for (int d = 0; d < D; d++) begin mark_busy(t, p); t++; end
        mark_busy(t, p);
        if (t < MAXC) begin exp_tr[t].res_valid = 1'b1; exp_tr[t].base = 4'(p * 4); end
        t++;
      end
      if (t < MAXC) exp_tr[t].done = 1'b1;
      c = t + 1;
    end
  endtask

  task automatic run_trace(input string tag, output int done_cyc, output int n_done,
                           output int n_res, output int n_iss);
    obs_t o, e;
    done_cyc = -1; n_done = 0; n_res = 0; n_iss = 0;
    for (int c = 0; c < MAXC; c++) begin
      start = st[c]; w_ready = wr[c]; abort = 1'b0;
      @(negedge clk);
      o = sample();
      e = exp_tr[c];
      check($sformatf("%s c%0d", tag, c), mask(o, e), mask(e, e));
      if (o.done) begin n_done++; if (done_cyc < 0) done_cyc = c; end
      if (o.res_valid) n_res++;
      if (o.act_re) n_iss++;
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic clear_stim(input logic wr_val);
    for (int i = 0; i < MAXC; i++) begin st[i] = 1'b0; wr[i] = wr_val; end
  endtask

  initial begin
    obs_t o;
    int dc, nd, nr, ni, n, nclr, nres;

    // Directed N=8 no-stall timeline
    for (int c = 0; c < 27; c++) begin
      vec[c] = '0;
      vec[c].start = (c == 0);
      vec[c].w_ready = 1'b1;
      if (c >= 1 && c <= 24) begin
        vec[c].exp.busy = 1'b1;
        vec[c].exp.acc_sel = (c >= 13) ? 3'd1 : 3'd0;
      end
      if (c == 1 || c == 13) vec[c].exp.clear = 4'hF;
      if (c >= 2 && c <= 9) begin
        vec[c].exp.act_re = 1'b1; vec[c].exp.w_re = 1'b1;
        vec[c].exp.act_addr = 3'(c - 2); vec[c].exp.w_col = 3'(c - 2);
        vec[c].exp.w_row_tile = 2'd0;
      end
      if (c >= 14 && c <= 21) begin
        vec[c].exp.act_re = 1'b1; vec[c].exp.w_re = 1'b1;
        vec[c].exp.act_addr = 3'(c - 14); vec[c].exp.w_col = 3'(c - 14);
        vec[c].exp.w_row_tile = 2'd1;
      end
      if ((c >= 3 && c <= 10) || (c >= 15 && c <= 22)) begin
        vec[c].exp.vwi = 4'hF; vec[c].exp.valid_ctrl = 12'h249;
      end
      if (c == 12) vec[c].exp.res_valid = 1'b1;
      if (c == 24) begin vec[c].exp.res_valid = 1'b1; vec[c].exp.base = 4'd4; end
      if (c == 25) vec[c].exp.done = 1'b1;
    end

    start16 = 1'b0; abort16 = 1'b0; w_ready16 = 1'b1;

    // Reset state
    do_reset();
    @(negedge clk);
    check("reset outputs", sample(), '0);
    check("reset n16", {busy16, done16, res_valid16, clear16, res_row_base16}, '0);
    @(posedge clk); #1;

    // Table-driven no-stall run
    for (int c = 0; c < 27; c++) begin
      start = vec[c].start; w_ready = vec[c].w_ready; abort = 1'b0;
      @(negedge clk);
      o = sample();
      check($sformatf("table c%0d", c), mask(o, vec[c].exp), mask(vec[c].exp, vec[c].exp));
      @(posedge clk); #1;
    end

    // Stall: w_ready low for 3 cycles mid pass 0
    do_reset();
    clear_stim(1'b1);
    st[0] = 1'b1; wr[5] = 1'b0; wr[6] = 1'b0; wr[7] = 1'b0;
    build_model();
    run_trace("stall", dc, nd, nr, ni);
    check("stall done cycle", 64'(dc), 64'd28);
    check("stall issue count", 64'(ni), 64'd16);

    // Abort in ISSUE at col=3
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      start = (c == 0); w_ready = 1'b1; abort = (c == 5);
      @(negedge clk);
      o = sample();
      if (c == 4) check("abort pre col2", {o.act_re, o.act_addr}, {1'b1, 3'd2});
      if (c == 5) check("abort cycle", {o.act_re, o.busy}, {1'b0, 1'b1});
      if (c == 6) check("abort next idle",
                        {o.busy, o.done, o.act_re, o.clear, o.vwi, o.valid_ctrl, o.res_valid}, '0);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    n = 0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) n++;
      @(posedge clk); #1;
    end
    check("abort no done/busy", 64'(n), 64'd0);
    clear_stim(1'b1);
    st[0] = 1'b1;
    build_model();
    run_trace("restart", dc, nd, nr, ni);
    check("restart done cycle", 64'(dc), 64'd25);

    // start pulses while busy are ignored
    do_reset();
    clear_stim(1'b1);
    st[0] = 1'b1; st[5] = 1'b1; st[13] = 1'b1; st[25] = 1'b1;
    build_model();
    run_trace("busystart", dc, nd, nr, ni);
    check("busystart done count", 64'(nd), 64'd1);
    check("busystart res count", 64'(nr), 64'(P));

    // rst asserted in DRAIN
    do_reset();
    for (int c = 0; c <= 11; c++) begin
      start = (c == 0); w_ready = 1'b1; abort = 1'b0; rst = (c == 10);
      @(negedge clk);
      if (c == 10) check("drain strobe", valid_weight_in, 4'hF);
      if (c == 11) check("rst in drain", sample(), '0);
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Random w_ready / start against the model (also proves IDLE after rst)
    clear_stim(1'b1);
    for (int i = 0; i < MAXC; i++) begin
      wr[i] = ($urandom_range(0, 3) != 0);
      st[i] = ($urandom_range(0, 24) == 0);
    end
    st[0] = 1'b1;
    build_model();
    run_trace("random", dc, nd, nr, ni);

    // N=16: four passes
    do_reset();
    nclr = 0; nres = 0; nd = 0; dc = -1;
    for (int c = 0; c < 90; c++) begin
      start16 = (c == 0);
      @(negedge clk);
      if (clear16 == 4'hF) begin
        check($sformatf("n16 acc_sel clr%0d", nclr), acc_sel_tile16, 3'(nclr));
        nclr++;
      end
      if (res_valid16) begin
        check($sformatf("n16 base r%0d", nres), res_row_base16, 5'(nres * 4));
        nres++;
      end
      if (done16) begin nd++; if (dc < 0) dc = c; end
      @(posedge clk); #1;
    end
    start16 = 1'b0;
    check("n16 done cycle", 64'(dc), 64'd81);
    check("n16 res count", 64'(nres), 64'd4);
    check("n16 done count", 64'(nd), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
